// File: rtl/pwm_if.sv
// Register bus for the pwm peripheral: single-cycle write strobe, combinational read.
interface pwm_if;
  logic        write;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output write, output addr_i, output wdata_i, input rdata_o);
  modport slave  (input write, input addr_i, input wdata_i, output rdata_o);
endinterface

// File: rtl/pwm.sv
// Two-channel register-programmable PWM with per-channel prescaler, period and duty compare.
// Channel 2 is built only when the macro PWM_CH2_EN is defined; otherwise its outputs are 0 and its registers read 0.
module pwm_chan (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  wr_sel,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl,
  output logic [31:0] div,
  output logic [31:0] period,
  output logic [31:0] duty,
  output logic        pwm_out,
  output logic        oe
);
  logic [31:0] ctrl_r, div_r, period_r, duty_r;
  logic [31:0] pre_cnt_r, cnt_r;
  logic        en_s, div_en_s, tick_s, wrap_s;

  assign en_s     = ctrl_r[0];
  assign div_en_s = ctrl_r[2];

  // Register file, one-hot write select: ctrl, div, period, duty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_r   <= 32'd0;
      div_r    <= 32'd0;
      period_r <= 32'd0;
      duty_r   <= 32'd0;
    end else begin
      if (wr_sel[0]) ctrl_r   <= wdata;
      if (wr_sel[1]) div_r    <= wdata;
      if (wr_sel[2]) period_r <= wdata;
      if (wr_sel[3]) duty_r   <= wdata;
    end
  end

  // Prescaler tick and period-wrap decisions; >= lets a shrunken DIV/PERIOD recover on the next tick
  always_comb begin
    tick_s = 1'b0;
    wrap_s = 1'b0;
    if (!div_en_s || (div_r <= 32'd1)) begin
      tick_s = en_s;
    end else begin
      tick_s = en_s && (pre_cnt_r >= (div_r - 32'd1));
    end
    if (period_r == 32'd0) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = (cnt_r >= (period_r - 32'd1));
    end
  end

  // Prescaler and period counters, cleared whenever the channel is disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_r <= 32'd0;
      cnt_r     <= 32'd0;
    end else if (!en_s) begin
      pre_cnt_r <= 32'd0;
      cnt_r     <= 32'd0;
    end else begin
      if (tick_s || !div_en_s) begin
        pre_cnt_r <= 32'd0;
      end else begin
        pre_cnt_r <= pre_cnt_r + 32'd1;
      end
      if (tick_s) begin
        cnt_r <= wrap_s ? 32'd0 : (cnt_r + 32'd1);
      end
    end
  end

  assign pwm_out = en_s & (cnt_r < duty_r);
  assign oe      = ctrl_r[1];
  assign ctrl    = ctrl_r;
  assign div     = div_r;
  assign period  = period_r;
  assign duty    = duty_r;
endmodule

module pwm (
  input  logic clk_i,
  input  logic rst_ni,
  pwm_if.slave bus,
  output logic o_pwm,
  output logic o_pwm_2,
  output logic oe_pwm1,
  output logic oe_pwm2
);
  logic [3:0]  sel_s;
  logic        aligned_s;
  logic [3:0]  wr1_s;
  logic [31:0] ctrl1_s, div1_s, period1_s, duty1_s;
  logic [31:0] ctrl2_s, div2_s, period2_s, duty2_s;
  logic [31:0] rd1_s, rd2_s;

  function automatic logic [31:0] reg_mux(input logic [1:0] idx, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      2'd3:    return d;
      default: return 32'd0;
    endcase
  endfunction

  // Address decode: exact word match within 0x00-0x1C
  always_comb begin
    sel_s     = 4'b0000;
    aligned_s = (bus.addr_i[7:5] == 3'd0) && (bus.addr_i[1:0] == 2'd0);
    case (bus.addr_i[3:2])
      2'd0:    sel_s = 4'b0001;
      2'd1:    sel_s = 4'b0010;
      2'd2:    sel_s = 4'b0100;
      2'd3:    sel_s = 4'b1000;
      default: sel_s = 4'b0000;
    endcase
  end

  assign wr1_s = (bus.write && aligned_s && !bus.addr_i[4]) ? sel_s : 4'b0000;

  pwm_chan u_ch1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_sel  (wr1_s),
    .wdata   (bus.wdata_i),
    .ctrl    (ctrl1_s),
    .div     (div1_s),
    .period  (period1_s),
    .duty    (duty1_s),
    .pwm_out (o_pwm),
    .oe      (oe_pwm1)
  );

`ifdef PWM_CH2_EN
  logic [3:0] wr2_s;
  assign wr2_s = (bus.write && aligned_s && bus.addr_i[4]) ? sel_s : 4'b0000;

  pwm_chan u_ch2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_sel  (wr2_s),
    .wdata   (bus.wdata_i),
    .ctrl    (ctrl2_s),
    .div     (div2_s),
    .period  (period2_s),
    .duty    (duty2_s),
    .pwm_out (o_pwm_2),
    .oe      (oe_pwm2)
  );
`else
  assign ctrl2_s   = 32'd0;
  assign div2_s    = 32'd0;
  assign period2_s = 32'd0;
  assign duty2_s   = 32'd0;
  assign o_pwm_2   = 1'b0;
  assign oe_pwm2   = 1'b0;
`endif

  assign rd1_s = reg_mux(bus.addr_i[3:2], ctrl1_s, div1_s, period1_s, duty1_s);
  assign rd2_s = reg_mux(bus.addr_i[3:2], ctrl2_s, div2_s, period2_s, duty2_s);

  // Combinational read-back; unmapped addresses return 0
  always_comb begin
    bus.rdata_o = 32'd0;
    if (aligned_s && !bus.addr_i[4]) begin
      bus.rdata_o = rd1_s;
    end else if (aligned_s && bus.addr_i[4]) begin
      bus.rdata_o = rd2_s;
    end else begin
      bus.rdata_o = 32'd0;
    end
  end
endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: expected values queued at stimulus time, popped and asserted at sample time.
module tb_pwm;
  logic clk;
  logic rst_n;
  logic o_pwm, o_pwm_2, oe_pwm1, oe_pwm2;
  int   errors;
  int   checks;
  logic [31:0] sb[$];

  pwm_if bus();

  pwm dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .o_pwm   (o_pwm),
    .o_pwm_2 (o_pwm_2),
    .oe_pwm1 (oe_pwm1),
    .oe_pwm2 (oe_pwm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  // one write: strobe held across exactly one rising edge, returns on a falling edge
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.write   = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    @(negedge clk);
    bus.write   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.addr_i = a;
    push(exp);
    #1;
    check(tag, bus.rdata_o);
  endtask

  function automatic logic model_bit(input int unsigned div_eff, input int unsigned period,
                                     input int unsigned duty, input int unsigned idx);
    int unsigned c;
    c = idx / div_eff;
    if (period != 0) c = c % period;
    else c = 0;
    return c < duty;
  endfunction

  task automatic run_wave(input string tag, input int unsigned d1, input int unsigned p1,
                          input int unsigned u1, input int unsigned o1, input bit en2,
                          input int unsigned d2, input int unsigned p2, input int unsigned u2,
                          input int unsigned o2, input int n);
    for (int i = 0; i < n; i++) begin
      push({31'd0, model_bit(d1, p1, u1, i + o1)});
      push(en2 ? {31'd0, model_bit(d2, p2, u2, i + o2)} : 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      check({tag, "_ch1"}, {31'd0, o_pwm});
      check({tag, "_ch2"}, {31'd0, o_pwm_2});
      @(negedge clk);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.write   = 1'b0;
    bus.addr_i  = 8'h00;
    bus.wdata_i = 32'd0;
    repeat (3) @(negedge clk);

    push(32'd0); check("rst_o_pwm", {31'd0, o_pwm});
    push(32'd0); check("rst_oe1", {31'd0, oe_pwm1});
    push(32'd0); check("rst_o_pwm2", {31'd0, o_pwm_2});
    push(32'd0); check("rst_oe2", {31'd0, oe_pwm2});
    rst_n = 1'b1;
    @(negedge clk);
    rd("rst_ctrl1", 8'h00, 32'd0);
    rd("rst_duty1", 8'h0C, 32'd0);

    // ch1 prescaled: DIV=2 PERIOD=10 DUTY=6
    @(negedge clk);
    wr(8'h04, 32'd2);
    wr(8'h08, 32'd10);
    wr(8'h0C, 32'd6);
    wr(8'h00, 32'd7);
    push(32'd1); check("oe1_on", {31'd0, oe_pwm1});
    run_wave("div2", 2, 10, 6, 0, 1'b0, 1, 1, 0, 0, 40);

    // ch1 unprescaled: PERIOD=4 DUTY=1, restarted from cleared counters
    wr(8'h00, 32'd0);
    push(32'd0); check("dis_o_pwm", {31'd0, o_pwm});
    push(32'd0); check("dis_oe1", {31'd0, oe_pwm1});
    wr(8'h08, 32'd4);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'd3);
    run_wave("nodiv", 1, 4, 1, 0, 1'b0, 1, 1, 0, 0, 16);

    wr(8'h0C, 32'd0);
    run_wave("duty0", 1, 4, 0, 0, 1'b0, 1, 1, 0, 0, 8);
    wr(8'h08, 32'd10);
    wr(8'h0C, 32'd12);
    run_wave("duty_gt", 1, 10, 12, 0, 1'b0, 1, 1, 0, 0, 12);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd5);
    run_wave("per0", 1, 0, 5, 0, 1'b0, 1, 1, 0, 0, 6);

    wr(8'h00, 32'd0);
    push(32'd0); check("clr_o_pwm", {31'd0, o_pwm});
    push(32'd0); check("clr_oe1", {31'd0, oe_pwm1});
    wr(8'h08, 32'd4);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'd3);
    run_wave("restart", 1, 4, 1, 0, 1'b0, 1, 1, 0, 0, 8);

    // both channels running together
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd2);
    wr(8'h08, 32'd10);
    wr(8'h0C, 32'd6);
`ifdef PWM_CH2_EN
    wr(8'h14, 32'd1);
    wr(8'h18, 32'd8);
    wr(8'h1C, 32'd2);
    wr(8'h00, 32'd7);
    wr(8'h10, 32'd7);
    push(32'd1); check("oe1_dual", {31'd0, oe_pwm1});
    push(32'd1); check("oe2_dual", {31'd0, oe_pwm2});
    run_wave("dual", 2, 10, 6, 1, 1'b1, 1, 8, 2, 0, 32);
    rd("rb_ctrl2", 8'h10, 32'd7);
    rd("rb_div2", 8'h14, 32'd1);
    rd("rb_per2", 8'h18, 32'd8);
    rd("rb_duty2", 8'h1C, 32'd2);
`else
    wr(8'h00, 32'd7);
    wr(8'h10, 32'd7);
    push(32'd0); check("oe2_absent", {31'd0, oe_pwm2});
    run_wave("ch2_absent", 2, 10, 6, 1, 1'b0, 1, 1, 0, 0, 20);
    rd("rb_ctrl2_absent", 8'h10, 32'd0);
    rd("rb_div2_absent", 8'h14, 32'd0);
`endif
    rd("rb_ctrl1", 8'h00, 32'd7);
    rd("rb_div1", 8'h04, 32'd2);
    rd("rb_per1", 8'h08, 32'd10);
    rd("rb_duty1", 8'h0C, 32'd6);
    rd("rb_unmapped", 8'h40, 32'd0);
    rd("rb_unaligned", 8'h02, 32'd0);

    // asynchronous reset in the middle of a constant-high run
    @(negedge clk);
    wr(8'h0C, 32'd12);
    push(32'd1); check("pre_rst_high", {31'd0, o_pwm});
    #2;
    rst_n = 1'b0;
    #1;
    push(32'd0); check("arst_o_pwm", {31'd0, o_pwm});
    push(32'd0); check("arst_oe1", {31'd0, oe_pwm1});
    push(32'd0); check("arst_o_pwm2", {31'd0, o_pwm_2});
    push(32'd0); check("arst_oe2", {31'd0, oe_pwm2});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("post_ctrl1", 8'h00, 32'd0);
    rd("post_div1", 8'h04, 32'd0);
    rd("post_per1", 8'h08, 32'd0);
    rd("post_duty1", 8'h0C, 32'd0);
    rd("post_ctrl2", 8'h10, 32'd0);
    rd("post_duty2", 8'h1C, 32'd0);
    push(32'd0); check("post_o_pwm", {31'd0, o_pwm});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Two-channel, register-programmable PWM peripheral on a simple single-cycle write / combinational read register bus.
- Each channel has a clock prescaler (divisor), a period counter, a duty-cycle compare and a control register.
- Drives a PWM output and an output-enable per channel, intended for a pad/IO mux.
- Sits as a memory-mapped slave beside other SoC peripherals.

Parameters:
- none (register widths fixed at 32 bits; address width fixed at 8 bits)

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- write  input  1  write strobe; register at addr_i loaded with wdata_i on a rising clk_i edge while high
- addr_i  input  8  byte address of register
- wdata_i  input  32  write data
- rdata_o  output  32  read data, combinational from addr_i
- o_pwm  output  1  channel 1 PWM waveform
- o_pwm_2  output  1  channel 2 PWM waveform
- oe_pwm1  output  1  channel 1 output enable
- oe_pwm2  output  1  channel 2 output enable

Behaviour:
- Register map, exact 8-bit address match only; all registers 32-bit R/W:
  - Channel 1: 0x00 CTRL1, 0x04 DIV1, 0x08 PERIOD1, 0x0C DUTY1
  - Channel 2: 0x10 CTRL2, 0x14 DIV2, 0x18 PERIOD2, 0x1C DUTY2
  - Other addresses: writes ignored, reads return 0.
- CTRL bits:
  - bit0 EN: counters run.
  - bit1 OE: drives oe_pwmN directly.
  - bit2 DIV_EN: 1 = use DIV prescaler; 0 = tick every clock.
  - bits[31:3]: stored and read back, no function.
- Reset (async, rst_ni=0):
  - All registers and counters 0.
  - o_pwm, o_pwm_2, oe_pwm1, oe_pwm2 = 0.
  - rdata_o follows the register contents (0).
- Write: register updates at the rising edge where write=1; new value visible on rdata_o in the same cycle after that edge.
- Prescaler (per channel):
  - Counts clocks while EN=1 and DIV_EN=1.
  - Issues a tick when count reaches DIV-1, then wraps to 0.
  - DIV=0 or DIV=1 gives a tick every clock.
  - With DIV_EN=0, tick every clock.
- Period counter (per channel):
  - Increments on each tick.
  - Wraps to 0 on the tick where it is >= PERIOD-1; this also covers PERIOD reprogrammed below the current count (wraps on the next tick).
- Output: o_pwmN = EN & (cnt < DUTY), combinational from registered counter and registers.
  - DUTY=0: constant low.
  - DUTY >= PERIOD: constant high while EN.
  - PERIOD=0: counter held 0, output = EN & (DUTY != 0).
- EN cleared: prescaler and period counters synchronously cleared to 0; output low.
- PERIOD/DUTY/DIV writes take effect immediately (no shadow registers).
- Channels fully independent; simultaneous activity on both channels is legal.
- All comparisons unsigned, full 32-bit.

Optional Feature:
- Macro PWM_CH2_EN.
- Defined: channel 2 is implemented as described.
- Undefined: channel 2 logic is absent:
  - o_pwm_2 and oe_pwm2 tied 0.
  - Addresses 0x10–0x1C read 0; writes to them are ignored.

Test Plan:
- Reset asserted mid-run -> all outputs 0 immediately (asynchronous); all registers read 0 after release.
- Ch1: DIV=2, PERIOD=10, DUTY=6, CTRL=7 -> oe_pwm1=1; o_pwm high 12 clocks, low 8 clocks, period 20 clocks; o_pwm_2=0.
- Ch1 CTRL=3 (DIV_EN=0), PERIOD=4, DUTY=1 -> o_pwm high 1 clock, low 3 clocks, repeating.
- DUTY=0 -> o_pwm constant 0; DUTY=12 with PERIOD=10 -> constant 1; write CTRL=0 -> o_pwm 0, counters cleared; oe_pwm1=0.
- Ch2 at 0x10–0x1C: DIV=1, PERIOD=8, DUTY=2, CTRL=7 -> o_pwm_2 high 2 of every 8 clocks, running concurrently with ch1; readback of every register matches written values; read 0x40 returns 0.
- Build without PWM_CH2_EN: write 0x10=7 -> readback 0; o_pwm_2 and oe_pwm2 remain 0.
